booth_radix4_seq_mul: RTL

Iterative radix-4 Booth multiplier with a parameterised operand width and a per-operation signed/unsigned mode. It retires one Booth digit per clock through a single partial-product generator and a shift-accumulate datapath. Valid/ready handshakes on both the operand and result sides let it sit between pipeline stages in the arithmetic datapath. It replaces fully combinational Booth partial-product arrays where area matters more than latency.

---
 rtl/booth_radix4_seq_mul_pkg.sv | 24 ++
 rtl/booth_pp_gen.sv | 38 +++
 rtl/booth_radix4_seq_mul.sv | 116 +++++++++++
 3 files changed

// File: rtl/booth_radix4_seq_mul_pkg.sv
// Shared arithmetic definitions for the radix-4 Booth multiplier family.
//   booth_digit_t : one recoded Booth digit (zero / double / negation flags)
//   state_t       : sequencer states for the iterative multiplier
//   booth_iter()  : number of Booth digits retired per operation for a width
package booth_radix4_seq_mul_pkg;

  typedef struct packed {
    logic zero;
    logic dbl;
    logic neg;
  } booth_digit_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // One extra digit beyond WIDTH/2 carries the unsigned-mode correction.
  function automatic int booth_iter(input int width);
    return width / 2 + 1;
  endfunction

endpackage

// File: rtl/booth_pp_gen.sv
// Radix-4 Booth digit encoder and partial-product generator (combinational).
//   win_i   : 3-bit multiplier window {b[2k+1], b[2k], b[2k-1]}
//   a_ext_i : multiplicand extended to WIDTH+2 bits
//   digit_o : encoded digit flags
//   pp_o    : digit * a_ext as a WIDTH+3-bit signed value
module booth_pp_gen
  import booth_radix4_seq_mul_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [2:0]              win_i,
  input  logic [WIDTH+1:0]        a_ext_i,
  output booth_digit_t            digit_o,
  output logic signed [WIDTH+2:0] pp_o
);

  logic             zero;
  logic             dbl;
  logic             neg;
  logic [WIDTH+2:0] mag;

  always_comb begin
    zero = (win_i == 3'b000) || (win_i == 3'b111);
    dbl  = (win_i == 3'b011) || (win_i == 3'b100);
    neg  = win_i[2] && !zero;
    // |2*a| of a WIDTH+2-bit value fits in WIDTH+3 bits, so negation cannot overflow.
    mag  = dbl ? {a_ext_i, 1'b0} : {a_ext_i[WIDTH+1], a_ext_i};
    if (zero) begin
      pp_o = '0;
    end else if (neg) begin
      pp_o = -mag;
    end else begin
      pp_o = mag;
    end
    digit_o = '{zero: zero, dbl: dbl, neg: neg};
  end

endmodule

// File: rtl/booth_radix4_seq_mul.sv
// Iterative radix-4 Booth multiplier, one digit per clock, valid/ready on both sides.
//   clk_i, rst_i             : clock, synchronous active-high reset
//   in_valid_i / in_ready_o  : operand handshake (ready only in IDLE)
//   a_i, b_i, is_signed_i    : multiplicand, multiplier, operand mode
//   out_valid_o / out_ready_i: result handshake (valid only in DONE)
//   product_o                : exact 2*WIDTH-bit product
//
// state   | meaning
// --------+--------------------------------------------------
// ST_IDLE | waiting for operands, in_ready_o high
// ST_BUSY | retiring one Booth digit per cycle (ITER cycles)
// ST_DONE | product held, out_valid_o high until out_ready_i
module booth_radix4_seq_mul
  import booth_radix4_seq_mul_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [WIDTH-1:0]     a_i,
  input  logic [WIDTH-1:0]     b_i,
  input  logic                 is_signed_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [2*WIDTH-1:0]   product_o
);

  localparam int ITER  = booth_iter(WIDTH);
  localparam int CNT_W = $clog2(ITER);
  localparam int ACC_W = 2 * WIDTH + 3;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(ITER - 1);

  if ((WIDTH % 2) != 0 || WIDTH < 4) begin : g_width_check
    $error("booth_radix4_seq_mul: WIDTH must be even and >= 4");
  end

  state_t                  state_q, state_d;
  logic [WIDTH+1:0]        a_ext_q;
  logic [WIDTH+2:0]        b_sh_q;
  logic [ACC_W-1:0]        acc_q;
  logic [CNT_W-1:0]        cnt_q;

  booth_digit_t            digit;
  logic signed [WIDTH+2:0] pp;
  logic [ACC_W-1:0]        pp_ext;
  logic [ACC_W-1:0]        pp_shift;
  logic                    unused_bits;

  // b is held shifted so the current window always sits in the low three bits.
  booth_pp_gen #(.WIDTH(WIDTH)) u_pp_gen (
    .win_i   (b_sh_q[2:0]),
    .a_ext_i (a_ext_q),
    .digit_o (digit),
    .pp_o    (pp)
  );

  assign pp_ext   = {{(ACC_W-WIDTH-3){pp[WIDTH+2]}}, pp};
  assign pp_shift = pp_ext << {cnt_q, 1'b0};

  // Double/negate are already folded into pp; only the high acc bits are truncated off.
  assign unused_bits = ^{digit.dbl, digit.neg, acc_q[ACC_W-1:2*WIDTH]};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (in_valid_i)       state_d = ST_BUSY;
      ST_BUSY: if (cnt_q == LAST)    state_d = ST_DONE;
      ST_DONE: if (out_ready_i)      state_d = ST_IDLE;
      default:                       state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      a_ext_q <= '0;
      b_sh_q  <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid_i) begin
            a_ext_q <= is_signed_i ? {{2{a_i[WIDTH-1]}}, a_i} : {2'b00, a_i};
            b_sh_q  <= is_signed_i ? {{2{b_i[WIDTH-1]}}, b_i, 1'b0}
                                   : {2'b00, b_i, 1'b0};
            acc_q   <= '0;
            cnt_q   <= '0;
          end
        end
        ST_BUSY: begin
          if (!digit.zero) begin
            acc_q <= acc_q + pp_shift;
          end
          cnt_q  <= cnt_q + 1'b1;
          b_sh_q <= b_sh_q >> 2;
        end
        default: ;
      endcase
    end
  end

  assign in_ready_o  = (state_q == ST_IDLE);
  assign out_valid_o = (state_q == ST_DONE);
  assign product_o   = acc_q[2*WIDTH-1:0];

endmodule
